// File: rtl/des_pkg.sv
// Shared DES tables, key-schedule shift amounts and controller state type.
package des_pkg;

  localparam int unsigned NROUNDS_DEF = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Left-rotate amount per round, rounds 1..16 at indices 0..15.
  localparam logic [1:0] SHIFT [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Entries are 1-based source bit numbers, DES bit 1 being the MSB.
  localparam byte unsigned IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam byte unsigned FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
  };

  localparam byte unsigned PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17, 9,   1, 58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27,  19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29,  21, 13, 5, 28, 20, 12, 4
  };

  localparam byte unsigned PC2_T [0:47] = '{
    14, 17, 11, 24, 1,  5,   3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,   16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_iter_ctrl_if.sv
// Block/result handshake and external f-function link for des_iter_ctrl.
// in_decrypt exists only when DES_DECRYPT_EN is defined.
interface des_iter_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
`ifdef DES_DECRYPT_EN
  logic        in_decrypt;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [31:0] f_r;
  logic [47:0] f_key;
  logic [31:0] f_result;
  logic        busy;

  modport master (
    output in_valid,
`ifdef DES_DECRYPT_EN
    output in_decrypt,
`endif
    output in_data, in_key, out_ready, f_result,
    input  in_ready, out_valid, out_data, f_r, f_key, busy
  );

  modport slave (
    input  in_valid,
`ifdef DES_DECRYPT_EN
    input  in_decrypt,
`endif
    input  in_data, in_key, out_ready, f_result,
    output in_ready, out_valid, out_data, f_r, f_key, busy
  );
endinterface

// File: rtl/des_key_sched.sv
// C/D key-schedule registers with per-round rotation and PC-2 subkey output.
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        load_mode,
  input  logic [63:0] key,
  input  logic [3:0]  round,
  output logic [47:0] subkey
);

  logic [27:0] c, d;
  logic        mode;
  logic [55:0] pc1;
  logic [3:0]  idx;
  logic [1:0]  amt;

  // Encrypt preloads the round-1 rotation and rotates ahead for the next round;
  // decrypt starts at K16 (PC-1 itself) and walks the schedule backwards.
  always_comb begin
    pc1 = pc1_f(key);
    idx = '0;
    amt = '0;
    if (mode) begin
      idx = 4'd15 - round;
      amt = SHIFT[idx];
    end else if (round != 4'd15) begin
      idx = round + 4'd1;
      amt = SHIFT[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c    <= '0;
      d    <= '0;
      mode <= 1'b0;
    end else if (load) begin
      mode <= load_mode;
      if (load_mode) begin
        c <= pc1[55:28];
        d <= pc1[27:0];
      end else begin
        c <= rotl28(pc1[55:28], SHIFT[0]);
        d <= rotl28(pc1[27:0], SHIFT[0]);
      end
    end else if (step) begin
      if (mode) begin
        c <= rotr28(c, amt);
        d <= rotr28(d, amt);
      end else begin
        c <= rotl28(c, amt);
        d <= rotl28(d, amt);
      end
    end
  end

  assign subkey = pc2_f({c, d});

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative one-round-per-clock DES sequencer with an external f-function.
// Define DES_DECRYPT_EN to add the in_decrypt mode input.
module des_iter_ctrl
  import des_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  des_iter_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  state_t      state;
  logic [3:0]  round;
  logic [31:0] l, r;
  logic [31:0] r_next;
  logic        load, step, load_mode;

  assign load   = (state == IDLE) && bus.in_valid;
  assign step   = (state == RUN);
  assign r_next = l ^ bus.f_result;
  assign bus.f_r = r;

`ifdef DES_DECRYPT_EN
  assign load_mode = bus.in_decrypt;
`else
  assign load_mode = 1'b0;
`endif

  des_key_sched u_key_sched (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .load_mode (load_mode),
    .key       (bus.in_key),
    .round     (round),
    .subkey    (bus.f_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      round         <= '0;
      l             <= '0;
      r             <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            {l, r}       <= ip_f(bus.in_data);
            round        <= '0;
            state        <= RUN;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        RUN: begin
          l     <= r;
          r     <= r_next;
          round <= round + 4'd1;
          if (round == LAST_ROUND) begin
            // Output swap folded in: FP is applied to {R16, L16}.
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_data  <= fp_f({r_next, r});
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Scoreboard bench for des_iter_ctrl; supplies the DES f-function (E, S, P) externally.
module tb_des_iter_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  typedef struct {
    logic [63:0] data;
    bit          chk;
  } exp_t;
  exp_t exp_q[$];
  logic [63:0] last_out = '0;

  des_iter_ctrl_if dif ();

  des_iter_ctrl #(.NROUNDS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam byte unsigned E_T [0:47] = '{
    32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,  24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1
  };
  localparam byte unsigned P_T [0:31] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };
  localparam byte unsigned SBOX [0:511] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  function automatic logic [31:0] f_fn(input logic [31:0] rr, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    int unsigned idx;
    e = '0;
    s = '0;
    p = '0;
    for (int unsigned i = 0; i < 48; i++) e[47-i] = rr[32-E_T[i]];
    e = e ^ k;
    for (int unsigned j = 0; j < 8; j++) begin
      b = e[47-6*j -: 6];
      idx = j*64 + int'({b[5], b[0]})*16 + int'(b[4:1]);
      s[31-4*j -: 4] = SBOX[idx][3:0];
    end
    for (int unsigned i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    return p;
  endfunction

  always_comb dif.f_result = f_fn(dif.f_r, dif.f_key);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Scoreboard monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dif.out_valid && dif.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %h expected none", dif.out_data);
      end else begin
        e = exp_q.pop_front();
        last_out = dif.out_data;
        if (e.chk) chk("out_data", dif.out_data, e.data);
      end
    end
  end

  task automatic push(input logic [63:0] d, input bit c);
    exp_t e;
    e.data = d;
    e.chk  = c;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] k, input bit dec,
                      output int unsigned acc);
    bit ok;
    ok = 0;
    acc = 0;
    dif.in_valid = 1'b1;
    dif.in_data  = d;
    dif.in_key   = k;
`ifdef DES_DECRYPT_EN
    dif.in_decrypt = dec;
`else
    if (dec) $display("decrypt requested in encrypt-only build");
`endif
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dif.in_ready) begin
        acc = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) flag("accept");
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned vc);
    bit ok;
    ok = 0;
    vc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dif.out_valid) begin
        vc = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) flag("out_valid");
  endtask

  task automatic drain(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) flag("drain");
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(dif.in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(dif.out_valid), 64'd0);
    chk({tag, "_out_data"},  dif.out_data, 64'd0);
    chk({tag, "_busy"},      64'(dif.busy), 64'd0);
    chk({tag, "_f_r"},       64'(dif.f_r), 64'd0);
    chk({tag, "_f_key"},     64'(dif.f_key), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;

  initial begin
    int unsigned a, v;
    int unsigned acc [4];
    logic [63:0] bb_key [4];
    logic [63:0] bb_pt  [4];
    logic [63:0] bb_ct  [4];
    bb_key = '{64'h1111111111111111, 64'h0123456789ABCDEF, 64'h1111111111111111, 64'hFEDCBA9876543210};
    bb_pt  = '{64'h1111111111111111, 64'h1111111111111111, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    bb_ct  = '{64'hF40379AB9E0EC533, 64'h17668DFC7292532D, 64'h8A5AE1F81AB8F2DD, 64'hED39D950FA74BCC4};

    dif.in_valid  = 1'b0;
    dif.in_data   = '0;
    dif.in_key    = '0;
    dif.out_ready = 1'b0;
`ifdef DES_DECRYPT_EN
    dif.in_decrypt = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reference vector with latency and round-1 subkey checks.
    dif.out_ready = 1'b1;
    push(CT1, 1);
    send(PT1, KEY1, 0, a);
    @(negedge clk);
    chk("round1_f_key", 64'(dif.f_key), 64'h1B02EFFC7072);
    chk("round1_f_r", 64'(dif.f_r), 64'hF0AAF0AA);
    chk("run_in_ready", 64'(dif.in_ready), 64'd0);
    chk("run_busy", 64'(dif.busy), 64'd1);
    wait_valid(v);
    chk("latency", 64'(v), 64'(a + 17));
    drain(40);

    push(64'h0000000000000000, 1);
    send(64'h8787878787878787, 64'h0E329232EA6D0D73, 0, a);
    drain(60);

    // Backpressure: result held, in_valid during DONE ignored.
    dif.out_ready = 1'b0;
    push(64'h8CA64DE9C1B123A7, 1);
    send(64'h0, 64'h0, 0, a);
    wait_valid(v);
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", 64'(dif.out_valid), 64'd1);
      chk("hold_in_ready", 64'(dif.in_ready), 64'd0);
      chk("hold_out_data", dif.out_data, 64'h8CA64DE9C1B123A7);
      if (i == 2) begin
        dif.in_valid = 1'b1;
        dif.in_data  = '1;
        dif.in_key   = '1;
      end
      @(negedge clk);
    end
    dif.in_valid = 1'b0;
    @(posedge clk); #1;
    dif.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_in_ready", 64'(dif.in_ready), 64'd1);
    chk("release_out_valid", 64'(dif.out_valid), 64'd0);
    chk("release_busy", 64'(dif.busy), 64'd0);
    @(posedge clk); #1;
    push(64'h7359B2163E4EDC58, 1);
    send(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, a);
    drain(60);

    // Asynchronous reset during round 7, checked before any clock edge.
    send(PT1, KEY1, 0, a);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(CT1, 1);
    send(PT1, KEY1, 0, a);
    drain(60);

    // Back-to-back with in_valid held: one accept every 18 cycles.
    for (int k = 0; k < 4; k++) push(bb_ct[k], 1);
    for (int k = 0; k < 4; k++) send(bb_pt[k], bb_key[k], 0, acc[k]);
    for (int k = 1; k < 4; k++) chk("b2b_spacing", 64'(acc[k] - acc[k-1]), 64'd18);
    drain(60);

`ifdef DES_DECRYPT_EN
    push(PT1, 1);
    send(CT1, KEY1, 1, a);
    drain(60);
    for (int n = 0; n < 1000; n++) begin
      logic [63:0] pt, key;
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom};
      push(64'h0, 0);
      send(pt, key, 0, a);
      drain(60);
      push(pt, 1);
      send(last_out, key, 1, a);
      drain(60);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
